// File: rtl/vga_fb_scanout_if.sv
// rtl/vga_fb_scanout_if.sv - frame-buffer read port between the scanout stage and its BRAM
//
// Purpose: carries the registered read address out to a synchronous-read
// frame-buffer BRAM and its read data back. Data is valid 1 clk after the
// address changes.
// Signals:
//   fb_addr  BRAM read address (driven by the scanout, master side)
//   fb_data  RGB444 read data  (driven by the BRAM, slave side)
interface vga_fb_scanout_if #(
  parameter int ADDR_W = 17
);
  logic [ADDR_W-1:0] fb_addr;
  logic [11:0]       fb_data;

  modport master (output fb_addr, input fb_data);
  modport slave  (input fb_addr, output fb_data);
endinterface

// File: rtl/vga_fb_scanout.sv
// rtl/vga_fb_scanout.sv - VGA pixel stage: frame-buffer fetch, RGB/sync alignment, frame counter
//
// Purpose: takes running pixel coordinates and sync levels from the VGA timing
// generator, issues an upscaled frame-buffer read address, and returns
// registered RGB444 with hs/vs delayed to stay aligned with it. Also emits a
// one-clk frame_start strobe at pixel (0,0) and a wrapping frame counter.
// Optional feature macro: VGA_TESTPAT_EN adds pattern_sel and 64-px colour bars.
// Ports:
//   clk, reset        50 MHz clock, synchronous active-high reset
//   p_tick            pixel enable (every other clk); all state advances on it
//   pixel_x, pixel_y  current coordinates; visible, hs_in, vs_in aligned to them
//   pattern_sel       colour-bar select (VGA_TESTPAT_EN only)
//   fb                frame-buffer read port (fb_addr out, fb_data in)
//   rgb, hs_out, vs_out   registered outputs, 2 pixel ticks behind the inputs
//   frame_start       1-clk pulse on the tick that samples (0,0)
//   frame_cnt         frames started since reset, wrapping
module vga_fb_scanout #(
  parameter int          FB_W     = 320,
  parameter int          FB_H     = 240,
  parameter int          SCALE_SH = 1,
  parameter int          OFF_X    = 0,
  parameter int          OFF_Y    = 0,
  parameter int          ADDR_W   = 17,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        visible,
  input  logic        hs_in,
  input  logic        vs_in,
`ifdef VGA_TESTPAT_EN
  input  logic        pattern_sel,
`endif
  vga_fb_scanout_if.master fb,
  output logic [11:0] rgb,
  output logic        hs_out,
  output logic        vs_out,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam logic [9:0]        OFF_X_C = 10'(OFF_X);
  localparam logic [9:0]        OFF_Y_C = 10'(OFF_Y);
  localparam logic [10:0]       FB_W_C  = 11'(FB_W);
  localparam logic [10:0]       FB_H_C  = 11'(FB_H);
  localparam logic [ADDR_W-1:0] FB_W_A  = ADDR_W'(FB_W);

  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic              vis_d1_q, vis_d1_d;
  logic              win_d1_q, win_d1_d;
  logic              hs_d1_q, hs_d1_d;
  logic              vs_d1_q, vs_d1_d;
  logic [11:0]       rgb_q, rgb_d;
  logic              hs_out_q, hs_out_d;
  logic              vs_out_q, vs_out_d;
  logic              frame_start_q, frame_start_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
`ifdef VGA_TESTPAT_EN
  logic [2:0]        bar_d1_q, bar_d1_d;
`endif

  logic [9:0]        lx, ly, sx, sy;
  logic              in_win;
  logic [ADDR_W-1:0] addr_calc;
  logic [11:0]       pix;

  always_comb begin
    // The >= guards keep coordinates left/above the window from wrapping
    // into a valid lx/ly; those pixels fall back to BG_COLOR.
    lx        = pixel_x - OFF_X_C;
    ly        = pixel_y - OFF_Y_C;
    sx        = lx >> SCALE_SH;
    sy        = ly >> SCALE_SH;
    in_win    = visible && (pixel_x >= OFF_X_C) && (pixel_y >= OFF_Y_C) &&
                ({1'b0, sx} < FB_W_C) && ({1'b0, sy} < FB_H_C);
    addr_calc = ADDR_W'(sy) * FB_W_A + ADDR_W'(sx);

    pix = win_d1_q ? fb.fb_data : BG_COLOR;
`ifdef VGA_TESTPAT_EN
    if (pattern_sel) begin
      pix = {{4{bar_d1_q[2]}}, {4{bar_d1_q[1]}}, {4{bar_d1_q[0]}}};
    end
`endif

    fb_addr_d     = fb_addr_q;
    vis_d1_d      = vis_d1_q;
    win_d1_d      = win_d1_q;
    hs_d1_d       = hs_d1_q;
    vs_d1_d       = vs_d1_q;
    rgb_d         = rgb_q;
    hs_out_d      = hs_out_q;
    vs_out_d      = vs_out_q;
    frame_cnt_d   = frame_cnt_q;
    // frame_start is the one flop that does not hold between ticks.
    frame_start_d = 1'b0;
`ifdef VGA_TESTPAT_EN
    bar_d1_d      = bar_d1_q;
`endif

    if (p_tick) begin
      fb_addr_d = in_win ? addr_calc : '0;
      vis_d1_d  = visible;
      win_d1_d  = in_win;
      hs_d1_d   = hs_in;
      vs_d1_d   = vs_in;
`ifdef VGA_TESTPAT_EN
      bar_d1_d  = pixel_x[8:6];
`endif
      // fb_data for the address issued on the previous tick is valid by now.
      rgb_d     = vis_d1_q ? pix : 12'h000;
      hs_out_d  = hs_d1_q;
      vs_out_d  = vs_d1_q;
      if (pixel_x == 10'd0 && pixel_y == 10'd0) begin
        frame_start_d = 1'b1;
        frame_cnt_d   = frame_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fb_addr_q     <= '0;
      vis_d1_q      <= 1'b0;
      win_d1_q      <= 1'b0;
      hs_d1_q       <= 1'b0;
      vs_d1_q       <= 1'b0;
      rgb_q         <= 12'h000;
      hs_out_q      <= 1'b0;
      vs_out_q      <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 16'd0;
`ifdef VGA_TESTPAT_EN
      bar_d1_q      <= 3'd0;
`endif
    end else begin
      fb_addr_q     <= fb_addr_d;
      vis_d1_q      <= vis_d1_d;
      win_d1_q      <= win_d1_d;
      hs_d1_q       <= hs_d1_d;
      vs_d1_q       <= vs_d1_d;
      rgb_q         <= rgb_d;
      hs_out_q      <= hs_out_d;
      vs_out_q      <= vs_out_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
`ifdef VGA_TESTPAT_EN
      bar_d1_q      <= bar_d1_d;
`endif
    end
  end

  assign fb.fb_addr  = fb_addr_q;
  assign rgb         = rgb_q;
  assign hs_out      = hs_out_q;
  assign vs_out      = vs_out_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb/tb_vga_fb_scanout.sv - scoreboard bench for vga_fb_scanout (default and offset-window instances)
module tb_vga_fb_scanout;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_tick;
  logic [9:0]  px, py;
  logic        vis, hs, vs;
  logic        psel;
  logic [11:0] rgb0, rgb1;
  logic        hs_out0, vs_out0, hs_out1, vs_out1;
  logic        fs0, fs1;
  logic [15:0] cnt0, cnt1;

  vga_fb_scanout_if #(.ADDR_W(17)) fb0 ();
  vga_fb_scanout_if #(.ADDR_W(17)) fb1 ();

  vga_fb_scanout dut0 (
    .clk(clk), .reset(reset), .p_tick(p_tick), .pixel_x(px), .pixel_y(py),
    .visible(vis), .hs_in(hs), .vs_in(vs),
`ifdef VGA_TESTPAT_EN
    .pattern_sel(psel),
`endif
    .fb(fb0.master), .rgb(rgb0), .hs_out(hs_out0), .vs_out(vs_out0),
    .frame_start(fs0), .frame_cnt(cnt0)
  );

  vga_fb_scanout #(
    .FB_W(160), .FB_H(120), .OFF_X(100), .OFF_Y(50), .BG_COLOR(12'h123)
  ) dut1 (
    .clk(clk), .reset(reset), .p_tick(p_tick), .pixel_x(px), .pixel_y(py),
    .visible(vis), .hs_in(hs), .vs_in(vs),
`ifdef VGA_TESTPAT_EN
    .pattern_sel(psel),
`endif
    .fb(fb1.master), .rgb(rgb1), .hs_out(hs_out1), .vs_out(vs_out1),
    .frame_start(fs1), .frame_cnt(cnt1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] mem_f(input int a);
    if (a == 322) return 12'hABC;
    return 12'((a * 37) ^ 32'h5A5);
  endfunction

  // Synchronous-read BRAM models: data 1 clk after the address.
  always @(posedge clk) fb0.fb_data <= mem_f(int'(fb0.fb_addr));
  always @(posedge clk) fb1.fb_data <= mem_f(int'(fb1.fb_addr));

  typedef struct {
    logic [11:0] rgb;
    logic [11:0] bar;
    bit          v;
    bit          h;
    bit          s;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  logic [15:0] cnt_m;
  int  hs_launch;
  bit  hs_armed;
  bit  hs_prev;
  int  hs_launches;
  int  hs_rises;

  function automatic void model(input int x, input int y, input bit v,
                                input int offx, input int offy, input int fbw, input int fbh,
                                input logic [11:0] bg, output int addr, output logic [11:0] col);
    int lx, ly;
    bit win;
    lx   = x - offx;
    ly   = y - offy;
    win  = v && lx >= 0 && ly >= 0 && (lx / 2) < fbw && (ly / 2) < fbh;
    addr = win ? (ly / 2) * fbw + (lx / 2) : 0;
    col  = !v ? 12'h000 : (win ? mem_f(addr) : bg);
  endfunction

  function automatic logic [11:0] exp_rgb(input ent_t e);
    if (!e.v) return 12'h000;
`ifdef VGA_TESTPAT_EN
    if (psel) return e.bar;
`endif
    return e.rgb;
  endfunction

  task automatic flush_queues();
    ent_t z;
    z = '{rgb: 12'h000, bar: 12'h000, v: 1'b0, h: 1'b0, s: 1'b0};
    q0.delete();
    q1.delete();
    q0.push_back(z);
    q1.push_back(z);
  endtask

  // Called at a negedge that follows a tick edge; returns at the negedge
  // after the next tick edge with p_tick low again.
  task automatic step(input int x, input int y, input bit v, input bit h, input bit s);
    ent_t e, o;
    int a0, a1;
    logic [11:0] c0, c1;
    if (h && !hs) begin
      hs_launch = cyc;
      hs_armed  = 1'b1;
      hs_launches++;
    end
    px = 10'(x); py = 10'(y); vis = v; hs = h; vs = s;
    p_tick = 1'b0;
    @(negedge clk);
    chk("frame_start_width", 32'(fs0), 32'd0);
    p_tick = 1'b1;
    @(negedge clk);
    p_tick = 1'b0;

    model(x, y, v, 0, 0, 320, 240, 12'h000, a0, c0);
    model(x, y, v, 100, 50, 160, 120, 12'h123, a1, c1);
    chk("fb_addr0", 32'(fb0.fb_addr), 32'(a0));
    chk("fb_addr1", 32'(fb1.fb_addr), 32'(a1));

    if (x == 0 && y == 0) cnt_m = cnt_m + 16'd1;
    chk("frame_start", 32'(fs0), 32'(x == 0 && y == 0));
    chk("frame_cnt", 32'(cnt0), 32'(cnt_m));

    e.bar = {{4{x[8]}}, {4{x[7]}}, {4{x[6]}}};
    e.v = v; e.h = h; e.s = s;
    e.rgb = c0;
    q0.push_back(e);
    e.rgb = c1;
    q1.push_back(e);
    if (q0.size() > 1) begin
      o = q0.pop_front();
      chk("rgb0", 32'(rgb0), 32'(exp_rgb(o)));
      chk("hs_out0", 32'(hs_out0), 32'(o.h));
      chk("vs_out0", 32'(vs_out0), 32'(o.s));
    end
    if (q1.size() > 1) begin
      o = q1.pop_front();
      chk("rgb1", 32'(rgb1), 32'(exp_rgb(o)));
      chk("hs_out1", 32'(hs_out1), 32'(o.h));
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_addr0"}, 32'(fb0.fb_addr), 32'd0);
    chk({tag, "_addr1"}, 32'(fb1.fb_addr), 32'd0);
    chk({tag, "_rgb0"},  32'(rgb0), 32'd0);
    chk({tag, "_rgb1"},  32'(rgb1), 32'd0);
    chk({tag, "_hs"},    32'({hs_out0, vs_out0, hs_out1, vs_out1}), 32'd0);
    chk({tag, "_fs"},    32'({fs0, fs1}), 32'd0);
    chk({tag, "_cnt"},   32'(cnt0), 32'd0);
  endtask

  // hs_out must rise exactly 4 clks after the tick edge that raised hs_in.
  always @(negedge clk) begin
    if (!reset && hs_out0 && !hs_prev && hs_armed) begin
      chk("hs_rise_latency", 32'(cyc - hs_launch), 32'd4);
      hs_armed = 1'b0;
      hs_rises++;
    end
    hs_prev = hs_out0;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int xs[13] = '{0, 1, 5, 63, 64, 319, 320, 639, 640, 656, 700, 752, 799};
  int ys[10] = '{0, 1, 3, 50, 239, 240, 479, 480, 490, 524};

  initial begin
    reset = 1'b1; p_tick = 1'b0; psel = 1'b0;
    px = '0; py = '0; vis = 1'b0; hs = 1'b0; vs = 1'b0;
    cnt_m = '0; hs_armed = 1'b0; hs_prev = 1'b0; hs_launches = 0; hs_rises = 0;
    repeat (3) @(negedge clk);
    check_reset_state("por");
    reset = 1'b0;
    flush_queues();

    // Mid-line traffic, then a 4-clk reset with p_tick still toggling.
    for (int i = 0; i < 6; i++) step(200 + i, 100, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      p_tick = ~p_tick;
    end
    check_reset_state("mid_rst");
    reset = 1'b0; p_tick = 1'b0;
    flush_queues();
    cnt_m = '0;
    for (int i = 0; i < 4; i++) step(300 + i, 100, 1'b1, 1'b0, 1'b0);
    chk("cnt_before_frame", 32'(cnt0), 32'd0);

    // Three compressed frames covering window edges, blanking and sync pulses.
    for (int f = 0; f < 3; f++)
      for (int yi = 0; yi < 10; yi++)
        for (int xi = 0; xi < 13; xi++)
          step(xs[xi], ys[yi], xs[xi] < 640 && ys[yi] < 480,
               xs[xi] >= 656 && xs[xi] < 752, ys[yi] >= 490 && ys[yi] < 492);
    chk("frame_cnt_3", 32'(cnt0), 32'd3);
    chk("frame_cnt_3_off", 32'(cnt1), 32'd3);

    // Directed points.
    step(5, 3, 1'b1, 1'b0, 1'b0);
    chk("addr_5_3", 32'(fb0.fb_addr), 32'd322);
    step(639, 479, 1'b1, 1'b0, 1'b0);
    chk("rgb_abc", 32'(rgb0), 32'h0ABC);
    chk("addr_max", 32'(fb0.fb_addr), 32'd76799);
    step(640, 479, 1'b0, 1'b0, 1'b0);
    chk("addr_blank", 32'(fb0.fb_addr), 32'd0);
    step(99, 50, 1'b1, 1'b0, 1'b0);
    chk("rgb_blank", 32'(rgb0), 32'd0);
    step(100, 50, 1'b1, 1'b0, 1'b0);
    chk("off_left_bg", 32'(rgb1), 32'h123);
    chk("off_origin_addr", 32'(fb1.fb_addr), 32'd0);
    step(420, 50, 1'b1, 1'b0, 1'b0);
    chk("off_right_addr", 32'(fb1.fb_addr), 32'd0);
    chk("off_origin_rgb", 32'(rgb1), 32'h5A5);
    step(10, 10, 1'b1, 1'b0, 1'b0);
    chk("off_right_bg", 32'(rgb1), 32'h123);

`ifdef VGA_TESTPAT_EN
    psel = 1'b1;
    step(64, 10, 1'b1, 1'b0, 1'b0);
    step(448, 10, 1'b1, 1'b0, 1'b0);
    chk("bar_1", 32'(rgb0), 32'h00F);
    step(700, 10, 1'b0, 1'b0, 1'b0);
    chk("bar_7", 32'(rgb0), 32'hFFF);
    step(5, 10, 1'b1, 1'b0, 1'b0);
    chk("bar_blank", 32'(rgb0), 32'h000);
    psel = 1'b0;
    step(6, 10, 1'b1, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 4; i++) step(20 + i, 20, 1'b1, 1'b0, 1'b0);
    chk("hs_rise_count", 32'(hs_rises), 32'(hs_launches));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
